// File: rtl/bitstream_window.sv
// bitstream_window: byte-serial 32-bit MSB-aligned bit window with flush and refill.
// Optional byte-boundary align flush is enabled by BITSTREAM_WINDOW_ALIGN_EN.
module bitstream_window #(
    parameter int BYTES       = 2048,
    parameter int START_LEVEL = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        in_byte_valid,
    output logic        in_byte_ready,
    input  logic [5:0]  flush_n,
    input  logic        flush_valid,
    output logic        flush_ready,
    input  logic        align_valid,
    output logic        align_ready,
    output logic [31:0] ld_bfr,
    output logic [5:0]  incnt,
    output logic        window_valid,
    output logic        eos,
    output logic        err
);
    localparam int CW = $clog2(BYTES + 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t        state;
    logic [CW-1:0] byte_cnt;
    logic [CW-1:0] cnt_nxt;
    logic          cnt_full;
    logic          flush_acc;
    logic          byte_acc;
    logic [5:0]    shamt;
    logic [5:0]    c;
    logic [5:0]    incnt_nxt;
    logic [31:0]   bfr_nxt;

    assign cnt_full      = (byte_cnt == CW'(BYTES));
    assign in_byte_ready = (incnt <= 6'd24) && !cnt_full;
    assign flush_ready   = (state != S_FILL) && (flush_n <= incnt);
    assign flush_acc     = flush_valid && flush_ready;
    assign byte_acc      = in_byte_valid && in_byte_ready;
    assign window_valid  = (state != S_FILL);

`ifdef BITSTREAM_WINDOW_ALIGN_EN
    logic align_acc;
    assign align_ready = (state != S_FILL) && !flush_valid;
    assign align_acc   = align_valid && align_ready;
`else
    logic unused_align;
    assign unused_align = align_valid;
    assign align_ready  = 1'b0;
`endif

    // Retire first, then insert the new byte just below the surviving bits.
    always_comb begin
        shamt = 6'd0;
        if (flush_acc) begin
            shamt = flush_n;
        end
`ifdef BITSTREAM_WINDOW_ALIGN_EN
        else if (align_acc) begin
            shamt = {3'd0, incnt[2:0]};
        end
`endif
        c         = incnt - shamt;
        bfr_nxt   = ld_bfr << shamt;
        incnt_nxt = c;
        cnt_nxt   = byte_cnt;
        if (byte_acc) begin
            bfr_nxt   = bfr_nxt | ({in_byte, 24'd0} >> c);
            incnt_nxt = c + 6'd8;
            cnt_nxt   = byte_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FILL;
            ld_bfr   <= '0;
            incnt    <= '0;
            byte_cnt <= '0;
            eos      <= 1'b0;
            err      <= 1'b0;
        end else begin
            ld_bfr   <= bfr_nxt;
            incnt    <= incnt_nxt;
            byte_cnt <= cnt_nxt;
            if (flush_valid && (flush_n > 6'd32)) begin
                err <= 1'b1;
            end
            if ((cnt_nxt == CW'(BYTES)) && (incnt_nxt == 6'd0)) begin
                eos <= 1'b1;
            end
            case (state)
                S_FILL: begin
                    if (cnt_full || (incnt >= 6'(START_LEVEL))) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (cnt_full) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: state <= S_DRAIN;
                default: state <= S_FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_bitstream_window.sv
// Self-checking bench for bitstream_window: directed scenarios plus random
// traffic against a bit-queue reference model.
module tb_bitstream_window;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_byte = 8'd0;
    logic        in_byte_valid = 1'b0;
    logic        flush_valid = 1'b0;
    logic        align_valid = 1'b0;
    logic [5:0]  flush_n = 6'd0;
    logic        sel4 = 1'b0;

    logic        ibr_a, fr_a, ar_a, wv_a, eos_a, err_a;
    logic [31:0] ld_a;
    logic [5:0]  inc_a;
    logic        ibr_b, fr_b, ar_b, wv_b, eos_b, err_b;
    logic [31:0] ld_b;
    logic [5:0]  inc_b;

    logic        ibr, fr, ar, wv, eos, err;
    logic [31:0] ld;
    logic [5:0]  incnt;

    assign ibr   = sel4 ? ibr_b : ibr_a;
    assign fr    = sel4 ? fr_b  : fr_a;
    assign ar    = sel4 ? ar_b  : ar_a;
    assign wv    = sel4 ? wv_b  : wv_a;
    assign eos   = sel4 ? eos_b : eos_a;
    assign err   = sel4 ? err_b : err_a;
    assign ld    = sel4 ? ld_b  : ld_a;
    assign incnt = sel4 ? inc_b : inc_a;

    bitstream_window dut (
        .clk(clk), .rst(rst),
        .in_byte(in_byte), .in_byte_valid(in_byte_valid), .in_byte_ready(ibr_a),
        .flush_n(flush_n), .flush_valid(flush_valid), .flush_ready(fr_a),
        .align_valid(align_valid), .align_ready(ar_a),
        .ld_bfr(ld_a), .incnt(inc_a), .window_valid(wv_a),
        .eos(eos_a), .err(err_a)
    );

    bitstream_window #(.BYTES(4), .START_LEVEL(32)) dut4 (
        .clk(clk), .rst(rst),
        .in_byte(in_byte), .in_byte_valid(in_byte_valid), .in_byte_ready(ibr_b),
        .flush_n(flush_n), .flush_valid(flush_valid), .flush_ready(fr_b),
        .align_valid(align_valid), .align_ready(ar_b),
        .ld_bfr(ld_b), .incnt(inc_b), .window_valid(wv_b),
        .eos(eos_b), .err(err_b)
    );

    always #5 clk = ~clk;

    // Reference model: the unconsumed stream as a queue of bits, oldest first.
    bit mq[$];
    int m_cnt = 0;
    bit m_started = 0;
    bit m_eos = 0;
    bit m_err = 0;
    int n_checks = 0;
    int n_pass = 0;

    function automatic logic [31:0] mwin();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < mq.size(); i++) w[31-i] = mq[i];
        return w;
    endfunction

    function automatic int nbytes();
        return sel4 ? 4 : 2048;
    endfunction

    task automatic tick();
        bit fa, aa, ba, st;
        int n, k;
        n  = int'(flush_n);
        fa = flush_valid && m_started && (n <= mq.size());
`ifdef BITSTREAM_WINDOW_ALIGN_EN
        aa = align_valid && m_started && !flush_valid;
`else
        aa = 0;
`endif
        ba = in_byte_valid && (mq.size() <= 24) && (m_cnt < nbytes());
        st = m_started || (mq.size() >= 32) || (m_cnt == nbytes());
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_cnt = 0;
            m_started = 0;
            m_eos = 0;
            m_err = 0;
        end else begin
            if (flush_valid && n > 32) m_err = 1;
            k = fa ? n : (aa ? mq.size() % 8 : 0);
            for (int i = 0; i < k; i++) void'(mq.pop_front());
            if (ba) begin
                for (int i = 7; i >= 0; i--) mq.push_back(in_byte[i]);
                m_cnt++;
            end
            m_started = st;
            if (m_cnt == nbytes() && mq.size() == 0) m_eos = 1;
        end
    endtask

    task automatic drive(input bit bv, input logic [7:0] b, input bit fv,
                         input logic [5:0] fn, input bit av);
        in_byte_valid = bv;
        in_byte = b;
        flush_valid = fv;
        flush_n = fn;
        align_valid = av;
        tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 8'h00, 0, 6'd0, 0);
        rst = 1'b0;
    endtask

    task automatic feed4(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) drive(1, w[i*8 +: 8], 0, 6'd0, 0);
    endtask

    task automatic test_reset();
        sel4 = 0;
        do_reset();
        n_checks++; if (ld !== 32'h0) $display("FAIL rst_ld got %h exp 0", ld); else n_pass++;
        n_checks++; if (incnt !== 6'd0) $display("FAIL rst_incnt got %0d exp 0", incnt); else n_pass++;
        n_checks++; if (wv !== 1'b0) $display("FAIL rst_wv got %b exp 0", wv); else n_pass++;
        n_checks++; if (eos !== 1'b0) $display("FAIL rst_eos got %b exp 0", eos); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL rst_err got %b exp 0", err); else n_pass++;
        n_checks++; if (ibr !== 1'b1) $display("FAIL rst_ibr got %b exp 1", ibr); else n_pass++;
        n_checks++; if (fr !== 1'b0) $display("FAIL rst_fr got %b exp 0", fr); else n_pass++;
        n_checks++; if (ar !== 1'b0) $display("FAIL rst_ar got %b exp 0", ar); else n_pass++;
    endtask

    task automatic test_fill_flush();
        sel4 = 0;
        do_reset();
        feed4(32'hA53CF00F);
        n_checks++; if (ld !== 32'hA53CF00F) $display("FAIL fill_ld got %h exp a53cf00f", ld); else n_pass++;
        n_checks++; if (incnt !== 6'd32) $display("FAIL fill_incnt got %0d exp 32", incnt); else n_pass++;
        n_checks++; if (ibr !== 1'b0) $display("FAIL fill_ibr got %b exp 0", ibr); else n_pass++;
        n_checks++; if (wv !== 1'b0) $display("FAIL fill_wv_early got %b exp 0", wv); else n_pass++;
        drive(0, 8'h00, 0, 6'd0, 0);
        n_checks++; if (wv !== 1'b1) $display("FAIL fill_wv got %b exp 1", wv); else n_pass++;
        drive(0, 8'h00, 1, 6'd3, 0);
        n_checks++; if (ld !== 32'h29E78078) $display("FAIL flush3_ld got %h exp 29e78078", ld); else n_pass++;
        n_checks++; if (incnt !== 6'd29) $display("FAIL flush3_incnt got %0d exp 29", incnt); else n_pass++;
        drive(0, 8'h00, 1, 6'd5, 0);
        n_checks++; if (ld !== 32'h3CF00F00) $display("FAIL flush5_ld got %h exp 3cf00f00", ld); else n_pass++;
        n_checks++; if (incnt !== 6'd24) $display("FAIL flush5_incnt got %0d exp 24", incnt); else n_pass++;
        drive(1, 8'h81, 0, 6'd0, 0);
        n_checks++; if (ld !== 32'h3CF00F81) $display("FAIL refill_ld got %h exp 3cf00f81", ld); else n_pass++;
        n_checks++; if (incnt !== 6'd32) $display("FAIL refill_incnt got %0d exp 32", incnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        sel4 = 0;
        do_reset();
        feed4(32'hA53CF00F);
        drive(0, 8'h00, 0, 6'd0, 0);
        drive(0, 8'h00, 1, 6'd8, 0);
        n_checks++; if (ld !== 32'h3CF00F00) $display("FAIL b2b_pre_ld got %h exp 3cf00f00", ld); else n_pass++;
        drive(1, 8'h81, 1, 6'd8, 0);
        n_checks++; if (ld !== 32'hF00F8100) $display("FAIL b2b_ld got %h exp f00f8100", ld); else n_pass++;
        n_checks++; if (incnt !== 6'd24) $display("FAIL b2b_incnt got %0d exp 24", incnt); else n_pass++;
        drive(1, 8'h55, 1, 6'd0, 0);
        n_checks++; if (ld !== 32'hF00F8155) $display("FAIL flush0_ld got %h exp f00f8155", ld); else n_pass++;
    endtask

    task automatic test_err();
        in_byte_valid = 0;
        flush_valid = 1;
        flush_n = 6'd33;
        #1;
        n_checks++; if (fr !== 1'b0) $display("FAIL err_fr got %b exp 0", fr); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (err !== 1'b1) $display("FAIL err_set got %b exp 1", err); else n_pass++;
        n_checks++; if (ld !== 32'hF00F8155) $display("FAIL err_ld got %h exp f00f8155", ld); else n_pass++;
        n_checks++; if (incnt !== 6'd32) $display("FAIL err_incnt got %0d exp 32", incnt); else n_pass++;
        drive(0, 8'h00, 1, 6'd32, 0);
        n_checks++; if (ld !== 32'h0) $display("FAIL flush32_ld got %h exp 0", ld); else n_pass++;
        n_checks++; if (incnt !== 6'd0) $display("FAIL flush32_incnt got %0d exp 0", incnt); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL err_sticky got %b exp 1", err); else n_pass++;
    endtask

    task automatic test_align();
        sel4 = 0;
        do_reset();
        feed4(32'hA53CF00F);
        drive(0, 8'h00, 0, 6'd0, 0);
        drive(0, 8'h00, 1, 6'd3, 0);
        in_byte_valid = 0;
        flush_valid = 0;
        align_valid = 1;
        #1;
`ifdef BITSTREAM_WINDOW_ALIGN_EN
        n_checks++; if (ar !== 1'b1) $display("FAIL align_ar got %b exp 1", ar); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (ld !== 32'h3CF00F00) $display("FAIL align_ld got %h exp 3cf00f00", ld); else n_pass++;
        n_checks++; if (incnt !== 6'd24) $display("FAIL align_incnt got %0d exp 24", incnt); else n_pass++;
`else
        n_checks++; if (ar !== 1'b0) $display("FAIL align_ar got %b exp 0", ar); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (ld !== 32'h29E78078) $display("FAIL noalign_ld got %h exp 29e78078", ld); else n_pass++;
        n_checks++; if (incnt !== 6'd29) $display("FAIL noalign_incnt got %0d exp 29", incnt); else n_pass++;
`endif
        align_valid = 0;
    endtask

    task automatic test_bytes4();
        sel4 = 1;
        do_reset();
        feed4(32'h11223344);
        n_checks++; if (ld !== 32'h11223344) $display("FAIL b4_ld got %h exp 11223344", ld); else n_pass++;
        n_checks++; if (ibr !== 1'b0) $display("FAIL b4_ibr_full got %b exp 0", ibr); else n_pass++;
        drive(1, 8'h55, 0, 6'd0, 0);
        n_checks++; if (wv !== 1'b1) $display("FAIL b4_wv got %b exp 1", wv); else n_pass++;
        drive(0, 8'h00, 1, 6'd8, 0);
        n_checks++; if (ld !== 32'h22334400) $display("FAIL b4_flush8_ld got %h exp 22334400", ld); else n_pass++;
        n_checks++; if (ibr !== 1'b0) $display("FAIL b4_ibr_cnt got %b exp 0", ibr); else n_pass++;
        drive(1, 8'h99, 0, 6'd0, 0);
        n_checks++; if (incnt !== 6'd24) $display("FAIL b4_noaccept got %0d exp 24", incnt); else n_pass++;
        n_checks++; if (eos !== 1'b0) $display("FAIL b4_eos_early got %b exp 0", eos); else n_pass++;
        drive(0, 8'h00, 1, 6'd24, 0);
        n_checks++; if (incnt !== 6'd0) $display("FAIL b4_drain_incnt got %0d exp 0", incnt); else n_pass++;
        n_checks++; if (eos !== 1'b1) $display("FAIL b4_eos got %b exp 1", eos); else n_pass++;
        n_checks++; if (ibr !== 1'b0) $display("FAIL b4_ibr_eos got %b exp 0", ibr); else n_pass++;
        do_reset();
        n_checks++; if (ld !== 32'h0) $display("FAIL b4_rst_ld got %h exp 0", ld); else n_pass++;
        n_checks++; if (incnt !== 6'd0) $display("FAIL b4_rst_incnt got %0d exp 0", incnt); else n_pass++;
        n_checks++; if (wv !== 1'b0) $display("FAIL b4_rst_wv got %b exp 0", wv); else n_pass++;
        n_checks++; if (eos !== 1'b0) $display("FAIL b4_rst_eos got %b exp 0", eos); else n_pass++;
        n_checks++; if (ibr !== 1'b1) $display("FAIL b4_rst_ibr got %b exp 1", ibr); else n_pass++;
        n_checks++; if (fr !== 1'b0) $display("FAIL b4_rst_fr got %b exp 0", fr); else n_pass++;
        sel4 = 0;
    endtask

    task automatic test_random();
        bit e_ibr, e_fr, e_ar;
        int k;
        sel4 = 0;
        do_reset();
        k = 0;
        while (m_cnt < 2048 && k < 30000) begin
            in_byte_valid = ($urandom_range(0, 3) != 0);
            in_byte = 8'($urandom);
            flush_valid = $urandom_range(0, 1) == 1;
            flush_n = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(33, 63))
                                                   : 6'($urandom_range(0, 32));
            align_valid = $urandom_range(0, 1) == 1;
            #1;
            e_ibr = (mq.size() <= 24) && (m_cnt < 2048);
            e_fr = m_started && (int'(flush_n) <= mq.size());
`ifdef BITSTREAM_WINDOW_ALIGN_EN
            e_ar = m_started && !flush_valid;
`else
            e_ar = 0;
`endif
            n_checks++; if (ibr !== e_ibr) $display("FAIL rnd_ibr cyc %0d got %b exp %b", k, ibr, e_ibr); else n_pass++;
            n_checks++; if (fr !== e_fr) $display("FAIL rnd_fr cyc %0d got %b exp %b", k, fr, e_fr); else n_pass++;
            n_checks++; if (ar !== e_ar) $display("FAIL rnd_ar cyc %0d got %b exp %b", k, ar, e_ar); else n_pass++;
            tick();
            @(negedge clk);
            n_checks++; if (ld !== mwin()) $display("FAIL rnd_ld cyc %0d got %h exp %h", k, ld, mwin()); else n_pass++;
            n_checks++; if (incnt !== 6'(mq.size())) $display("FAIL rnd_incnt cyc %0d got %0d exp %0d", k, incnt, mq.size()); else n_pass++;
            n_checks++; if (wv !== m_started) $display("FAIL rnd_wv cyc %0d got %b exp %b", k, wv, m_started); else n_pass++;
            n_checks++; if (eos !== m_eos) $display("FAIL rnd_eos cyc %0d got %b exp %b", k, eos, m_eos); else n_pass++;
            n_checks++; if (err !== m_err) $display("FAIL rnd_err cyc %0d got %b exp %b", k, err, m_err); else n_pass++;
            k++;
        end
        n_checks++; if (m_cnt != 2048) $display("FAIL rnd_budget got %0d bytes exp 2048", m_cnt); else n_pass++;
        for (int d = 0; d < 4 && mq.size() > 0; d++) begin
            drive(0, 8'h00, 1, 6'(mq.size()), 0);
        end
        n_checks++; if (incnt !== 6'd0) $display("FAIL rnd_drain_incnt got %0d exp 0", incnt); else n_pass++;
        n_checks++; if (eos !== 1'b1) $display("FAIL rnd_drain_eos got %b exp 1", eos); else n_pass++;
        n_checks++; if (ibr !== 1'b0) $display("FAIL rnd_drain_ibr got %b exp 0", ibr); else n_pass++;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill_flush();
        test_back_to_back();
        test_err();
        test_align();
        test_bytes4();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
